// File: rtl/tx_mod.sv
// tx_mod: UART transmitter. Sends start bit, NB_DATA data bits LSB first,
// then a stop period of STOP_TICKS sample ticks (16 ticks per bit period).
// The line bit is held in a register so o_tx has no combinational input path.
module tx_mod #(
    parameter int NB_DATA    = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_tx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Last tick index of a start/data bit and of the stop period.
    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(STOP_TICKS - 1);
    localparam logic [2:0] LAST_BIT  = 3'(NB_DATA - 1);

    state_t             state_q, state_d;
    logic [4:0]         tick_q, tick_d;
    logic [2:0]         bit_q, bit_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               done;

    // Next-state logic. tx_d is loaded with the value the line must carry
    // after the edge, so each bit lines up exactly with its tick window.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (i_tx_start) begin
                    shreg_d = i_tx_data;
                    tick_d  = 5'd0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = 5'd0;
                        bit_d   = 3'd0;
                        tx_d    = shreg_q[0];
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = 5'd0;
                        shreg_d = {1'b0, shreg_q[NB_DATA-1:1]};
                        if (bit_q == LAST_BIT) begin
                            bit_d   = 3'd0;
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = shreg_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (i_s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        done    = 1'b1;
                        tick_d  = 5'd0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset returns the line to idle-high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            tick_q  <= 5'd0;
            bit_q   <= 3'd0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_tx_done_tick = done;
    assign o_tx_busy      = (state_q != IDLE);

endmodule

// File: doc/tx_mod.md
TX_MOD -- requirements
Module: tx_mod

Interface
REQ-001 Parameter NB_DATA, default 8: data bits per frame; legal range 5..8.
REQ-002 Parameter STOP_TICKS, default 16: stop-bit length in sample ticks; legal values 16 (1 stop bit), 24 (1.5 stop bits) or 32 (2 stop bits).
REQ-003 i_clk  input  1  system clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_s_tick  input  1  one-clock sample-tick pulse from the baud-rate generator; 16 ticks per bit period.
REQ-006 i_tx_start  input  1  request to send a frame; sampled only in IDLE.
REQ-007 i_tx_data  input  NB_DATA  byte to transmit; captured in the same cycle the request is accepted.
REQ-008 o_tx  output  1  serial line; registered output; idles high.
REQ-009 o_tx_done_tick  output  1  one-clock pulse marking frame completion.
REQ-010 o_tx_busy  output  1  high from the clock after acceptance through the final stop tick.

Function
REQ-011 States SHALL be IDLE, START, DATA and STOP, held in a 2-bit state register.
REQ-012 The block SHALL keep the following registers: a tick counter wide enough to reach STOP_TICKS-1 (5 bits), a 3-bit data-bit counter, an NB_DATA shift register and a registered line bit.
REQ-013 In IDLE, o_tx SHALL be 1.
REQ-014 In IDLE, when i_tx_start=1, the block SHALL load the shift register with i_tx_data, clear the tick counter, set the line bit to 0 and go to START on the next edge, whether or not i_s_tick is high.
REQ-015 START SHALL hold o_tx=0 for exactly 16 i_s_tick pulses; on the 16th (tick counter = 15) it SHALL clear both counters and go to DATA.
REQ-016 DATA SHALL drive o_tx from shift-register bit 0 (LSB first), holding each bit for 16 ticks.
REQ-017 In DATA, at tick counter = 15 the shift register SHALL shift right by one and the data-bit counter SHALL increment.
REQ-018 In DATA, after bit NB_DATA-1 completes, the block SHALL clear the tick counter, drive o_tx=1 and go to STOP.
REQ-019 STOP SHALL hold o_tx=1 for STOP_TICKS ticks.
REQ-020 On the tick where the tick counter = STOP_TICKS-1, the block SHALL assert o_tx_done_tick for that single clock and return to IDLE on the same edge.
REQ-021 The tick counter and data-bit counter SHALL advance only on clocks with i_s_tick=1; without ticks all state is held.
REQ-022 i_tx_start and i_tx_data SHALL be ignored outside IDLE; a transmitted frame is never corrupted by input changes mid-frame.
REQ-023 i_tx_start=1 in the same cycle as o_tx_done_tick SHALL be ignored; a request held high SHALL be accepted on the following clock (back-to-back frames with no extra idle ticks).
REQ-024 A full frame SHALL last (1+NB_DATA)*16 + STOP_TICKS ticks: 160 ticks for defaults.
REQ-025 o_tx SHALL be a register output with no combinational path from the inputs.
REQ-026 o_tx_done_tick SHALL never be high for two consecutive clocks.
REQ-027 The default state-case branch SHALL go to IDLE with o_tx=1.

Reset
REQ-028 While i_reset=1 the block SHALL, on the clock edge: set state IDLE, clear both counters, clear the shift register, set o_tx=1, o_tx_done_tick=0 and o_tx_busy=0.
REQ-029 Reset SHALL take priority over i_tx_start.
REQ-030 Reset mid-frame SHALL abort the frame with o_tx=1 from the next edge and no done pulse.

Verification
REQ-031 Defaults, tick every 4th clock, send 0xA5 -> o_tx shows 0; bits 1,0,1,0,0,1,0,1; then 1; each bit is 16 ticks (64 clocks); one done pulse after 160 ticks.
REQ-032 Send 0x00, then 0xFF -> line low for 9 bit periods, then high for 9 bit periods (start bit low); done pulses 160 ticks apart.
REQ-033 i_tx_start held high, data 0x3C then 0xC3 -> second start bit begins the clock after the first done pulse; the frames have no gap.
REQ-034 Change i_tx_data and pulse i_tx_start at tick 50 of a frame carrying 0x55 -> the frame on the wire is still 0x55; no second frame follows.
REQ-035 Assert i_reset for 1 clock at tick 70 of a frame -> o_tx=1 and o_tx_busy=0 next clock; no done pulse; a new frame of 0x81 then transmits correctly.
REQ-036 STOP_TICKS=32, send 0x01 -> stop bit high for 32 ticks; done pulse at tick 176.
